// File: rtl/ts_pkg.sv
// Shared TS framing constants and receiver state encoding, reused by
// ts_serial_rx, ts_proxy and ts_ci.
package ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } ts_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ts_sync_edge.sv
// Two-stage synchronizer for the demod serial TS lines, plus a ts_clk
// rising-edge detect from a third ts_clk stage.
module ts_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ts_clk,
    input  logic ts_data,
    input  logic ts_valid,
    input  logic ts_start,
    output logic data_s,
    output logic valid_s,
    output logic start_s,
    output logic clk_rise
);

    // All four lines share the same depth so data stays aligned with its edge.
    logic [3:0] q1;
    logic [3:0] q2;
    logic       q3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
            q3 <= 1'b0;
        end else begin
            q1 <= {ts_start, ts_valid, ts_data, ts_clk};
            q2 <= q1;
            q3 <= q2[0];
        end
    end

    assign data_s   = q2[1];
    assign valid_s  = q2[2];
    assign start_s  = q2[3];
    assign clk_rise = q2[0] & ~q3;

endmodule

// File: rtl/ts_serial_rx.sv
// Serial MPEG-TS receiver: deserializes one demod port into bytes, checks
// sync/length framing and hands whole packets to the ts_proxy input mux.
module ts_serial_rx
    import ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
    parameter int         LOCK_PKTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ts_clk,
    input  logic        ts_data,
    input  logic        ts_valid,
    input  logic        ts_start,
    output logic [7:0]  out_data,
    output logic        out_wrreq,
    output logic        out_sop,
    output logic        out_abort,
    input  logic        out_almost_full,
    output logic        locked,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
    localparam int         LW        = $clog2(LOCK_PKTS + 1);
    localparam logic [LW-1:0] LOCK_M1 = LW'(LOCK_PKTS - 1);

    logic data_s, valid_s, start_s, clk_rise;

    ts_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .ts_clk  (ts_clk),
        .ts_data (ts_data),
        .ts_valid(ts_valid),
        .ts_start(ts_start),
        .data_s  (data_s),
        .valid_s (valid_s),
        .start_s (start_s),
        .clk_rise(clk_rise)
    );

    ts_state_t     state;
    logic [6:0]    shift;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_cnt;
    logic [LW-1:0] good_cnt;

    logic       bit_ev;
    logic       mid_pkt;
    logic [7:0] new_byte;

    assign bit_ev   = clk_rise & valid_s;
    assign mid_pkt  = (bit_cnt != 3'd0) || (byte_cnt != 8'd0);
    assign new_byte = {shift, data_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            shift     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            good_cnt  <= '0;
            out_data  <= '0;
            out_wrreq <= 1'b0;
            out_sop   <= 1'b0;
            out_abort <= 1'b0;
            locked    <= 1'b0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            out_wrreq <= 1'b0;
            out_sop   <= 1'b0;
            out_abort <= 1'b0;
            if (!enable) begin
                // In RECV a non-zero byte_cnt means downstream holds a partial packet.
                if (state == RECV && byte_cnt != 8'd0)
                    out_abort <= 1'b1;
                state    <= HUNT;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (bit_ev) begin
                if (start_s && (state == HUNT || mid_pkt)) begin
                    if (state != HUNT) begin
                        err_count <= sat_inc(err_count);
                        locked    <= 1'b0;
                        good_cnt  <= '0;
                        if (state == RECV && byte_cnt != 8'd0)
                            out_abort <= 1'b1;
                    end
                    shift    <= {6'd0, data_s};
                    bit_cnt  <= 3'd1;
                    byte_cnt <= 8'd0;
                    state    <= out_almost_full ? DROP : RECV;
                end else if (state != HUNT) begin
                    shift   <= {shift[5:0], data_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == RECV && byte_cnt == 8'd0 && new_byte != SYNC_BYTE) begin
                            err_count <= sat_inc(err_count);
                            locked    <= 1'b0;
                            good_cnt  <= '0;
                            state     <= HUNT;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            if (state == RECV) begin
                                out_data  <= new_byte;
                                out_wrreq <= 1'b1;
                                out_sop   <= (byte_cnt == 8'd0);
                            end
                            if (byte_cnt == LAST_BYTE) begin
                                state    <= HUNT;
                                byte_cnt <= 8'd0;
                                if (state == RECV) begin
                                    pkt_count <= sat_inc(pkt_count);
                                    if (!locked) begin
                                        if (good_cnt == LOCK_M1)
                                            locked <= 1'b1;
                                        else
                                            good_cnt <= good_cnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_serial_rx.sv
// Directed bench for ts_serial_rx: a table of packet scenarios plus
// hand-written sequences for enable drop and asynchronous reset.
module tb_ts_serial_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ts_clk = 1'b0;
    logic        ts_data = 1'b0;
    logic        ts_valid = 1'b0;
    logic        ts_start = 1'b0;
    logic [7:0]  out_data;
    logic        out_wrreq;
    logic        out_sop;
    logic        out_abort;
    logic        out_almost_full = 1'b0;
    logic        locked;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    ts_serial_rx dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .ts_clk         (ts_clk),
        .ts_data        (ts_data),
        .ts_valid       (ts_valid),
        .ts_start       (ts_start),
        .out_data       (out_data),
        .out_wrreq      (out_wrreq),
        .out_sop        (out_sop),
        .out_abort      (out_abort),
        .out_almost_full(out_almost_full),
        .locked         (locked),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_total = 0;
    int sop_total = 0;
    int abort_total = 0;
    bit both_seen = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (out_wrreq) begin
                wr_total++;
                if (out_sop) sop_total++;
                got_q.push_back(out_data);
            end
            if (out_abort) abort_total++;
            if (out_wrreq && out_abort) both_seen = 1'b1;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string name);
        int bad = 0;
        if (got_q.size() != exp_q.size()) bad = 1;
        else foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) bad++;
        check({name, "_data_bad"}, bad, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    // One ts_clk period = 4 clk; data changes while ts_clk is low.
    task automatic send_bit(input logic d, input logic v, input logic s);
        @(negedge clk);
        ts_clk = 1'b0; ts_data = d; ts_valid = v; ts_start = s;
        @(negedge clk);
        @(negedge clk);
        ts_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit first, input int gap_bit);
        for (int k = 7; k >= 0; k--) begin
            if (k == gap_bit)
                for (int g = 0; g < 20; g++) send_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0);
            send_bit(b[k], 1'b1, first && (k == 7));
        end
    endtask

    task automatic send_packet(input logic [7:0] first, input bit af, input int nbytes,
                               input int gap_byte, input bit expect_out);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = (i == 0) ? first : 8'(i - 1);
            if (i == 0 && af) out_almost_full = 1'b1;
            if (i == 5) out_almost_full = 1'b0;
            send_byte(b, i == 0, (i == gap_byte) ? 4 : -1);
            if (expect_out) exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ts_clk = 1'b0; ts_valid = 1'b0; ts_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] first;
        bit         af;
        int         trunc;
        int         gap;
        int         e_wr;
        int         e_sop;
        int         e_abort;
        int         e_pkt;
        int         e_err;
        int         e_locked;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int wr0, sop0, ab0;

        vecs[0] = '{8'h47, 1'b0, 0,   -1, 188, 1, 0, 1, 0, 0};
        vecs[1] = '{8'h47, 1'b0, 0,   -1, 188, 1, 0, 2, 0, 1};
        vecs[2] = '{8'h47, 1'b0, 0,   -1, 188, 1, 0, 3, 0, 1};
        vecs[3] = '{8'h46, 1'b0, 0,   -1, 0,   0, 0, 3, 1, 0};
        vecs[4] = '{8'h47, 1'b0, 0,   -1, 188, 1, 0, 4, 1, 0};
        vecs[5] = '{8'h47, 1'b0, 100, -1, 288, 2, 1, 5, 2, 0};
        vecs[6] = '{8'h47, 1'b1, 0,   -1, 0,   0, 0, 5, 2, 0};
        vecs[7] = '{8'h47, 1'b0, 0,   -1, 188, 1, 0, 6, 2, 1};
        vecs[8] = '{8'h47, 1'b0, 0,   50, 188, 1, 0, 7, 2, 1};

        repeat (4) @(negedge clk);
        check("rst_out_data", int'(out_data), 0);
        check("rst_wrreq", int'(out_wrreq), 0);
        check("rst_sop", int'(out_sop), 0);
        check("rst_abort", int'(out_abort), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_pkt_count", int'(pkt_count), 0);
        check("rst_err_count", int'(err_count), 0);
        reset = 1'b0;
        enable = 1'b1;
        idle(4);

        for (int v = 0; v < 9; v++) begin
            wr0 = wr_total; sop0 = sop_total; ab0 = abort_total;
            if (vecs[v].trunc > 0)
                send_packet(8'h47, 1'b0, vecs[v].trunc, -1, 1'b1);
            send_packet(vecs[v].first, vecs[v].af, 188, vecs[v].gap,
                        (vecs[v].first == 8'h47) && !vecs[v].af);
            idle(12);
            check($sformatf("v%0d_wr", v), wr_total - wr0, vecs[v].e_wr);
            check($sformatf("v%0d_sop", v), sop_total - sop0, vecs[v].e_sop);
            check($sformatf("v%0d_abort", v), abort_total - ab0, vecs[v].e_abort);
            check($sformatf("v%0d_pkt", v), int'(pkt_count), vecs[v].e_pkt);
            check($sformatf("v%0d_err", v), int'(err_count), vecs[v].e_err);
            check($sformatf("v%0d_locked", v), int'(locked), vecs[v].e_locked);
            check_data($sformatf("v%0d", v));
        end

        // Asynchronous reset in the middle of a byte
        send_packet(8'h47, 1'b0, 50, -1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_data", int'(out_data), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_pkt_count", int'(pkt_count), 0);
        check("arst_err_count", int'(err_count), 0);
        check("arst_wrreq", int'(out_wrreq), 0);
        idle(3);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        idle(4);
        wr0 = wr_total; sop0 = sop_total;
        send_packet(8'h47, 1'b0, 188, -1, 1'b1);
        idle(12);
        check("arst_next_wr", wr_total - wr0, 188);
        check("arst_next_sop", sop_total - sop0, 1);
        check("arst_next_pkt", int'(pkt_count), 1);
        check_data("arst_next");

        // Enable dropped mid-packet after bytes were emitted
        ab0 = abort_total;
        send_packet(8'h47, 1'b0, 30, -1, 1'b1);
        idle(6);
        enable = 1'b0;
        idle(6);
        enable = 1'b1;
        check("en_abort", abort_total - ab0, 1);
        check("en_pkt", int'(pkt_count), 1);
        check("en_err", int'(err_count), 0);
        check_data("en_partial");
        wr0 = wr_total;
        send_packet(8'h47, 1'b0, 188, -1, 1'b1);
        idle(12);
        check("en_next_wr", wr_total - wr0, 188);
        check("en_next_pkt", int'(pkt_count), 2);
        check_data("en_next");

        check("wr_abort_overlap", int'(both_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ts_serial_rx.md
# ts_serial_rx

Serial MPEG-TS receiver for one demodulator port (Sony DVB, LG ATSC or Altobeam DTMB). It oversamples the demod's serial TS lines on the system clock, deserializes them into bytes and checks packet framing (sync 0x47, 188 bytes). It delivers whole packets, with start/abort markers, to the input mux in ts_proxy. One instance sits between each demod's TS pins and ts_proxy.

## Interface
Parameters:
- PKT_LEN, 188, bytes per TS packet
- SYNC_BYTE, 8'h47, required first byte
- LOCK_PKTS, 2, consecutive good packets before `locked` asserts

Ports:
- clk  in  1  system clock (usb_ulpi_clk, 60 MHz); the only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  receive enable; synchronous to clk
- ts_clk  in  1  demod serial TS clock; asynchronous; frequency ≤ clk/4
- ts_data  in  1  serial data, MSB first, sampled on ts_clk rising edge
- ts_valid  in  1  bit qualifier
- ts_start  in  1  high during bit 7 of the sync byte
- out_data  out  8  received byte
- out_wrreq  out  1  one-cycle strobe; out_data valid
- out_sop  out  1  high with the out_wrreq of byte 0
- out_abort  out  1  one-cycle pulse; downstream discards the partial packet
- out_almost_full  in  1  downstream backpressure
- locked  out  1  framing locked
- pkt_count  out  16  good packets delivered, saturating
- err_count  out  16  framing errors, saturating

## Operation
- ts_clk, ts_data, ts_valid and ts_start each pass through a 2-FF synchronizer with identical depth. A third register on ts_clk gives `edge = q2 & ~q3`.
- Sampling: bit event = edge & valid_s. Edges with valid_s=0 are gaps. They are ignored, with no error and no bit-count advance.
- States:
  - HUNT: on bit event with start_s=1, load the bit as bit 7, set bit_cnt=1 and byte_cnt=0, and go to RECV. If out_almost_full=1 at that moment, go to DROP instead.
  - RECV: shift bits in. On the 8th bit, form the byte.
    - byte_cnt=0 and byte≠SYNC_BYTE: err_count++, no output, go to HUNT.
    - Otherwise emit out_wrreq, with out_sop when byte_cnt=0, and increment byte_cnt.
    - After byte PKT_LEN-1: pkt_count++ and go to HUNT.
  - DROP: count bits and bytes identically but emit nothing. Return to HUNT after PKT_LEN bytes. No counter changes.
- Bit event with start_s=1 in RECV or DROP while (bit_cnt,byte_cnt)≠(0,0):
  - err_count++.
  - In RECV only: out_abort if at least one byte has been emitted.
  - The event is processed as a fresh HUNT start in the same cycle.
- enable=0: forced to HUNT, nothing emitted. Deasserting enable mid-packet in RECV with at least one byte emitted gives one out_abort pulse.
- locked:
  - Sets after LOCK_PKTS consecutive completed RECV packets.
  - Clears on any err_count increment or when enable=0.
  - DROP packets neither set nor clear it.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: state HUNT, all counters 0. out_data=0, out_wrreq=0, out_sop=0, out_abort=0, locked=0. Synchronizers cleared.
- Latency: out_wrreq is asserted 3 clk cycles after the ts_clk rising edge carrying the byte's last bit (2 sync + 1 output register). Edge-to-edge jitter is ±1 clk.
- out_wrreq, out_sop and out_abort are registered one-cycle pulses.
- out_abort and out_wrreq are never high in the same cycle.
- Consecutive out_wrreq pulses are ≥ 8×4 clk apart.
- out_almost_full is evaluated only at packet start. A packet that is accepted is always delivered complete unless it is aborted by framing.
- Reset mid-packet: immediate return to reset values. No abort pulse is generated; ts_proxy shares the same reset.

## Structure
- Shared package ts_pkg: TS_PKT_LEN=188, TS_SYNC_BYTE=8'h47, state encoding {HUNT, RECV, DROP}. ts_proxy and ts_ci reuse these.
- Sub-module ts_sync_edge: 4-bit synchronizer plus ts_clk rising-edge detect, reset-cleared.
- The top holds the FSM, shift register, bit_cnt[2:0], byte_cnt[7:0] and counters.

## Test plan
- 3 clean packets (0x47 then 0x00..0xBA), ts_clk=clk/4 -> 564 out_wrreq; out_sop on 3 bytes; pkt_count=3; locked=1 after the 2nd packet; err_count=0.
- First byte 0x46 -> no output, err_count=1, locked stays 0; the next good packet is delivered.
- ts_start re-asserted at byte 100 -> out_abort once, err_count=1; the new packet is delivered complete with out_sop.
- out_almost_full=1 at packet start, released mid-packet -> 0 writes for that packet; the following packet is delivered fully; pkt_count counts only the delivered packet.
- ts_valid low for 20 ts_clk cycles inside byte 50 -> byte values intact, no error.
- Async reset asserted mid-byte -> all outputs 0 within the same cycle; after release, the next packet is received normally.
